// File: rtl/sram_ctrl.sv
// MEM-stage responder driving a 32-bit asynchronous SRAM with timed CE/OE/WE strobes.
// Optional out-of-range rejection is enabled by defining SRAM_RANGE_CHECK_EN.
`timescale 1ns/1ps
module sram_ctrl #(
  parameter int ADDR_W    = 20,
  parameter int READ_WAIT = 2,
  parameter int WE_PULSE  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_data_i,
  input  logic              mem_ce_n_i,
  input  logic              mem_oe_n_i,
  input  logic              mem_we_n_i,
  input  logic [3:0]        mem_be_n_i,
  output logic [31:0]       mem_data_o,
  output logic              stall_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  input  logic [31:0]       sram_data_i,
  output logic [31:0]       sram_data_o,
  output logic              sram_data_oe_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [3:0]        sram_be_n_o
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD       = 3'd1;
  localparam logic [2:0] WR_SETUP = 3'd2;
  localparam logic [2:0] WR_PULSE = 3'd3;
  localparam logic [2:0] WR_HOLD  = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  localparam int CNT_MAX = (READ_WAIT > WE_PULSE) ? READ_WAIT : WE_PULSE;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  logic [2:0]        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [31:0]       rdata_reg, rdata_next;
  logic [3:0]        be_reg, be_next;
  logic              err_reg, err_next;
  logic              range_hit;
  logic              active_next, drive_next;
  logic              ce_n_reg, oe_n_reg, we_n_reg, doe_reg;
  logic [3:0]        be_n_reg;

`ifdef SRAM_RANGE_CHECK_EN
  logic unused_bits;
  assign range_hit   = |mem_addr_i[31:ADDR_W+2];
  assign unused_bits = ^mem_addr_i[1:0];
  assign err_o       = err_reg;
`else
  logic unused_bits;
  assign range_hit   = 1'b0;
  assign unused_bits = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0], err_reg};
  assign err_o       = 1'b0;
`endif

  assign stall_o = !rst && !mem_ce_n_i && (state_reg != DONE);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    be_next    = be_reg;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!mem_ce_n_i) begin
          if (range_hit) begin
            // Rejected requests never touch the SRAM pins; only a read clears the data.
            state_next = DONE;
            err_next   = 1'b1;
            if (mem_we_n_i && !mem_oe_n_i) rdata_next = 32'd0;
          end else begin
            addr_next  = mem_addr_i[ADDR_W+1:2];
            wdata_next = mem_data_i;
            be_next    = mem_be_n_i;
            if (!mem_we_n_i) begin
              state_next = WR_SETUP;
              cnt_next   = CNT_W'(WE_PULSE - 1);
            end else if (!mem_oe_n_i) begin
              state_next = RD;
              cnt_next   = CNT_W'(READ_WAIT - 1);
            end else begin
              state_next = DONE;
            end
          end
        end
      end
      RD: begin
        if (cnt_reg == '0) begin
          rdata_next = sram_data_i;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      WR_SETUP: state_next = WR_PULSE;
      WR_PULSE: begin
        if (cnt_reg == '0) state_next = WR_HOLD;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      WR_HOLD: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign drive_next  = (state_next == WR_SETUP) || (state_next == WR_PULSE) ||
                       (state_next == WR_HOLD);
  assign active_next = drive_next || (state_next == RD);

  // Strobes are registered from the next state so the SRAM pins never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      be_reg    <= 4'hF;
      err_reg   <= 1'b0;
      ce_n_reg  <= 1'b1;
      oe_n_reg  <= 1'b1;
      we_n_reg  <= 1'b1;
      doe_reg   <= 1'b0;
      be_n_reg  <= 4'hF;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      be_reg    <= be_next;
      err_reg   <= err_next;
      ce_n_reg  <= !active_next;
      oe_n_reg  <= (state_next != RD);
      we_n_reg  <= (state_next != WR_PULSE);
      doe_reg   <= drive_next;
      be_n_reg  <= active_next ? be_next : 4'hF;
    end
  end

  assign mem_data_o     = rdata_reg;
  assign sram_addr_o    = addr_reg;
  assign sram_data_o    = wdata_reg;
  assign sram_data_oe_o = doe_reg;
  assign sram_ce_n_o    = ce_n_reg;
  assign sram_oe_n_o    = oe_n_reg;
  assign sram_we_n_o    = we_n_reg;
  assign sram_be_n_o    = be_n_reg;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: directed test-plan steps then random traffic
// against a word-level memory model and a pin-level asynchronous SRAM model.
`timescale 1ns/1ps
module tb_sram_ctrl;
  localparam int ADDR_W    = 20;
  localparam int READ_WAIT = 2;
  localparam int WE_PULSE  = 2;
`ifdef SRAM_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] mem_addr_i = '0, mem_data_i = '0;
  logic mem_ce_n_i = 1'b1, mem_oe_n_i = 1'b1, mem_we_n_i = 1'b1;
  logic [3:0] mem_be_n_i = 4'hF;
  logic [31:0] mem_data_o, sram_data_i, sram_data_o;
  logic stall_o, err_o, sram_data_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [3:0] sram_be_n_o;

  int total = 0;
  int bad = 0;
  bit overlap_seen = 1'b0;
  bit mem_init = 1'b0;
  logic [31:0] sram_mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] last_rd = '0;

  always #5 clk = ~clk;

  sram_ctrl #(.ADDR_W(ADDR_W), .READ_WAIT(READ_WAIT), .WE_PULSE(WE_PULSE)) dut (
    .clk(clk), .rst(rst),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .mem_ce_n_i(mem_ce_n_i), .mem_oe_n_i(mem_oe_n_i), .mem_we_n_i(mem_we_n_i),
    .mem_be_n_i(mem_be_n_i), .mem_data_o(mem_data_o), .stall_o(stall_o), .err_o(err_o),
    .sram_addr_o(sram_addr_o), .sram_data_i(sram_data_i), .sram_data_o(sram_data_o),
    .sram_data_oe_o(sram_data_oe_o), .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
    .sram_we_n_o(sram_we_n_o), .sram_be_n_o(sram_be_n_o)
  );

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return (i == 4) ? 32'hDEADBEEF : {b, ~b, 8'h5A, b ^ 8'h3C};
  endfunction

  // Pin-level asynchronous SRAM: reads while CE/OE low, byte writes while CE/WE low.
  assign sram_data_i = (!sram_ce_n_o && !sram_oe_n_o) ? sram_mem[sram_addr_o[7:0]] : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) sram_mem[i] = init_word(i);
      mem_init = 1'b1;
    end
    if (!sram_ce_n_o && !sram_we_n_o && sram_data_oe_o)
      for (int b = 0; b < 4; b++)
        if (!sram_be_n_o[b]) sram_mem[sram_addr_o[7:0]][8*b +: 8] = sram_data_o[8*b +: 8];
  end

  always @(negedge clk)
    if (!rst && sram_data_oe_o && !sram_oe_n_o) overlap_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One MEM-stage request held until stall_o drops; returns in the DONE cycle.
  task automatic access(input logic we_n, input logic oe_n, input logic [3:0] be_n,
                        input logic [31:0] addr, input logic [31:0] data);
    int stalls, ce_lo, oe_lo, we_lo, doe, be_bad, addr_bad, wd_bad;
    int w, exp_stalls;
    bit done, oor, is_wr, is_rd;
    logic [ADDR_W-1:0] exp_addr;
    stalls = 0; ce_lo = 0; oe_lo = 0; we_lo = 0; doe = 0; be_bad = 0; addr_bad = 0; wd_bad = 0;
    done = 1'b0;
    exp_addr = addr[ADDR_W+1:2];
    w = int'(addr[9:2]);
    oor = RANGE_EN && (|addr[31:ADDR_W+2]);
    is_wr = !we_n && !oor;
    is_rd = we_n && !oe_n && !oor;
    @(negedge clk);
    mem_ce_n_i = 1'b0; mem_we_n_i = we_n; mem_oe_n_i = oe_n;
    mem_be_n_i = be_n; mem_addr_i = addr; mem_data_i = data;
    for (int k = 0; k < 64 && !done; k++) begin
      #1;
      if (!sram_ce_n_o) begin
        ce_lo++;
        if (sram_be_n_o !== be_n) be_bad++;
        if (sram_addr_o !== exp_addr) addr_bad++;
      end else if (sram_be_n_o !== 4'hF) be_bad++;
      if (!sram_oe_n_o) oe_lo++;
      if (!sram_we_n_o) we_lo++;
      if (sram_data_oe_o) begin
        doe++;
        if (sram_data_o !== data) wd_bad++;
      end
      if (!stall_o) done = 1'b1;
      else begin
        stalls++;
        @(negedge clk);
      end
    end
    check("done_reached", 32'(done), 32'd1);
    exp_stalls = is_wr ? WE_PULSE + 3 : (is_rd ? READ_WAIT + 1 : 1);
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));
    check("ce_low_cycles", 32'(ce_lo), 32'(is_wr ? WE_PULSE + 2 : (is_rd ? READ_WAIT : 0)));
    check("oe_low_cycles", 32'(oe_lo), 32'(is_rd ? READ_WAIT : 0));
    check("we_low_cycles", 32'(we_lo), 32'(is_wr ? WE_PULSE : 0));
    check("data_drive_cycles", 32'(doe), 32'(is_wr ? WE_PULSE + 2 : 0));
    check("be_mismatch", 32'(be_bad), 32'd0);
    check("addr_mismatch", 32'(addr_bad), 32'd0);
    check("wdata_mismatch", 32'(wd_bad), 32'd0);
    if (is_wr)
      for (int b = 0; b < 4; b++)
        if (!be_n[b]) ref_mem[w][8*b +: 8] = data[8*b +: 8];
    if (is_rd) last_rd = ref_mem[w];
    if (oor && we_n && !oe_n) last_rd = 32'd0;
    check("mem_data_o", mem_data_o, last_rd);
    check("err_o", 32'(err_o), 32'(oor));
    $display("txn we_n=%0b oe_n=%0b be_n=%b addr=%08h data=%08h stalls=%0d rd=%08h err=%0b",
             we_n, oe_n, be_n, addr, data, stalls, mem_data_o, err_o);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    mem_ce_n_i = 1'b1;
    mem_oe_n_i = 1'($urandom);
    mem_we_n_i = 1'($urandom);
  endtask

  initial begin
    logic [31:0] a, d;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_strobes", {28'd0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_data_oe_o}, 32'hE);
    check("rst_be", 32'(sram_be_n_o), 32'hF);
    check("rst_addr", 32'(sram_addr_o), 32'd0);
    check("rst_wdata", sram_data_o, 32'd0);
    check("rst_mem_data", mem_data_o, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Word read of 0x10 (SRAM word 4 holds DEADBEEF)
    access(1'b1, 1'b0, 4'b0000, 32'h0000_0010, 32'h0);
    check("rd_word_addr", 32'(sram_addr_o), 32'h4);
    idle_cycle();

    // Reset in the middle of a read
    @(negedge clk);
    mem_ce_n_i = 1'b0; mem_oe_n_i = 1'b0; mem_we_n_i = 1'b1; mem_addr_i = 32'h0000_0020;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_stall_now", 32'(stall_o), 32'd0);
    @(negedge clk);
    #1;
    check("midrst_strobes", {28'd0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_data_oe_o}, 32'hE);
    check("midrst_mem_data", mem_data_o, 32'd0);
    check("midrst_stall", 32'(stall_o), 32'd0);
    last_rd = 32'd0;
    mem_ce_n_i = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Byte write, back-to-back SW/LW, no-op, and write precedence
    access(1'b0, 1'b1, 4'b1011, 32'h0000_0022, 32'h5A5A5A5A);
    idle_cycle();
    access(1'b1, 1'b0, 4'b0000, 32'h0000_0020, 32'h0);
    access(1'b0, 1'b1, 4'b0000, 32'h0000_0100, 32'hCAFE_F00D);
    access(1'b1, 1'b0, 4'b0000, 32'h0000_0100, 32'h0);
    access(1'b1, 1'b1, 4'b0000, 32'h0000_0040, 32'h0);
    access(1'b0, 1'b0, 4'b0000, 32'h0000_0030, 32'h1234_5678);
    access(1'b1, 1'b0, 4'b0000, 32'h0000_0030, 32'h0);
    idle_cycle();
`ifdef SRAM_RANGE_CHECK_EN
    access(1'b1, 1'b0, 4'b0000, 32'h0040_0000, 32'h0);
    idle_cycle();
`endif

    // Random traffic over 16 words to force reuse and partial-byte merges
    for (int n = 0; n < 60; n++) begin
      int op;
      op = int'($urandom_range(0, 19));
      a = {(RANGE_EN ? 10'd0 : 10'($urandom)), 16'd0, 4'($urandom), 2'($urandom)};
      d = $urandom;
      if (op < 9)       access(1'b0, 1'($urandom), 4'($urandom), a, d);
      else if (op < 18) access(1'b1, 1'b0, 4'($urandom), a, d);
      else              access(1'b1, 1'b1, 4'($urandom), a, d);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();
    repeat (2) @(negedge clk);
    check("oe_drive_overlap", 32'(overlap_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
